// File: rtl/i2c_arbiter_pkg.sv
// Shared types and helpers for the I2C bus arbiter: FSM state encoding,
// counter-width helper and the default bus-free interval.
package i2c_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } arb_state_t;

    // 5 us bus-free time (100 kHz standard mode) at a 200 MHz system clock
    localparam int DEFAULT_BUS_FREE_CYCLES = 1000;

    // Bits needed to hold values 0..x-1, never less than one bit
    function automatic int clog2_min1(input int x);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(x)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/i2c_bus_free_detector.sv
// Synchronises the SCL/SDA pad readbacks and asserts bus_free once both lines
// have been high for BUS_FREE_CYCLES consecutive clocks; clear restarts the count.
module i2c_bus_free_detector
    import i2c_arbiter_pkg::*;
#(
    parameter int BUS_FREE_CYCLES = DEFAULT_BUS_FREE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    input  logic clear,
    output logic bus_free
);

    localparam int CW = clog2_min1(BUS_FREE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUS_FREE_CYCLES);

    logic [1:0]    scl_sync_reg;
    logic [1:0]    sda_sync_reg;
    logic [CW-1:0] free_cnt_reg;
    logic          lines_high;

    assign lines_high = scl_sync_reg[1] & sda_sync_reg[1];
    assign bus_free   = (free_cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg <= 2'b00;
            sda_sync_reg <= 2'b00;
            free_cnt_reg <= '0;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl_in};
            sda_sync_reg <= {sda_sync_reg[0], sda_in};
            if (clear || !lines_high) begin
                free_cnt_reg <= '0;
            end else if (free_cnt_reg != CNT_MAX) begin
                free_cnt_reg <= free_cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin request/grant arbiter sharing one open-drain I2C bus among masters.
// Optional hold timeout enabled by defining I2C_ARBITER_TIMEOUT_EN.
module i2c_bus_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS      = 2,
    parameter int BUS_FREE_CYCLES     = DEFAULT_BUS_FREE_CYCLES,
    parameter int HOLD_TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                      system_clock,
    input  logic                      system_reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    output logic [NUM_REQUESTERS-1:0] grant,
    input  logic [NUM_REQUESTERS-1:0] req_scl_output,
    input  logic [NUM_REQUESTERS-1:0] req_sda_output,
    input  logic                      scl_input,
    input  logic                      sda_input,
    output logic                      scl_output,
    output logic                      sda_output,
    output logic                      busy,
    output logic                      timeout
);

    localparam int N  = NUM_REQUESTERS;
    localparam int PW = clog2_min1(N);

    if (N < 2 || HOLD_TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_bus_arbiter: NUM_REQUESTERS must be >= 2 and HOLD_TIMEOUT_CYCLES >= 1");
    end

    arb_state_t      state_reg, state_next;
    logic [N-1:0]    grant_reg, grant_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic            scl_output_reg, sda_output_reg;
    logic [N-1:0]    scl_term, sda_term;
    logic [N-1:0]    eligible;
    logic            bus_free, free_clear, hold_expired;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    int              scan_idx;

    i2c_bus_free_detector #(
        .BUS_FREE_CYCLES(BUS_FREE_CYCLES)
    ) u_free_det (
        .clk      (system_clock),
        .rst_n    (system_reset_n),
        .scl_in   (scl_input),
        .sda_in   (sda_input),
        .clear    (free_clear),
        .bus_free (bus_free)
    );

`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam int HW = clog2_min1(HOLD_TIMEOUT_CYCLES);
    logic [HW-1:0] hold_cnt_reg;
    logic [N-1:0]  blocked_reg;
    logic          timeout_reg, timeout_fire;

    assign hold_expired = (hold_cnt_reg == HW'(HOLD_TIMEOUT_CYCLES - 1));
    assign timeout_fire = (state_reg == ST_GRANT) && hold_expired && request[owner_reg];
    assign eligible     = request & ~blocked_reg;
    assign timeout      = timeout_reg;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= (state_reg == ST_GRANT) ? hold_cnt_reg + HW'(1) : '0;
            timeout_reg  <= timeout_fire;
        end
    end

    // A timed-out master stays locked out until it withdraws its request
    for (genvar gi = 0; gi < N; gi++) begin : g_block
        always_ff @(posedge system_clock or negedge system_reset_n) begin
            if (!system_reset_n) begin
                blocked_reg[gi] <= 1'b0;
            end else if (timeout_fire && owner_reg == PW'(gi)) begin
                blocked_reg[gi] <= 1'b1;
            end else if (!request[gi]) begin
                blocked_reg[gi] <= 1'b0;
            end
        end
    end
`else
    assign hold_expired = 1'b0;
    assign eligible     = request;
    assign timeout      = 1'b0;
`endif

    // First eligible master at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(rr_ptr_reg) + k) % N;
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        free_clear  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_found && bus_free) begin
                    state_next          = ST_GRANT;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    owner_next          = win_idx;
                end
            end
            ST_GRANT: begin
                if (!request[owner_reg] || hold_expired) begin
                    state_next  = ST_COOLDOWN;
                    grant_next  = '0;
                    free_clear  = 1'b1;
                    rr_ptr_next = (owner_reg == PW'(N - 1)) ? '0 : owner_reg + PW'(1);
                end
            end
            ST_COOLDOWN: begin
                if (bus_free) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
        end
    end

    // Ungranted masters are forced to 1 so only the owner can pull the bus low
    for (genvar gi = 0; gi < N; gi++) begin : g_mux
        assign scl_term[gi] = ~grant_reg[gi] | req_scl_output[gi];
        assign sda_term[gi] = ~grant_reg[gi] | req_sda_output[gi];
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            scl_output_reg <= 1'b1;
            sda_output_reg <= 1'b1;
        end else begin
            scl_output_reg <= &scl_term;
            sda_output_reg <= &sda_term;
        end
    end

    assign grant      = grant_reg;
    assign scl_output = scl_output_reg;
    assign sda_output = sda_output_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule
